// File: rtl/laser_tx_sched.sv
// laser_tx_sched
// Round-robin scheduler that shares one serial laser transmitter between
// NUM_REQ requesters. It latches the winning packet, strobes the transmitter,
// waits for the transmitter to accept and finish, then holds the line idle for
// GAP_CLKS cycles. Every output is registered.
//
// Ports
//   clk       system clock
//   rst       synchronous, active-high reset
//   req       per-requester request level, held until grant
//   req_data  packet of requester i at [i*PKT_LENGTH +: PKT_LENGTH]
//   grant     one-hot 1-cycle pulse: packet latched (coincides with tx_start)
//   done      one-hot 1-cycle pulse: owner's packet fully sent
//   err       1-cycle pulse: tx_busy never rose after tx_start
//   tx_data   latched packet, stable from ISSUE until the next grant
//   tx_start  1-cycle start strobe to the transmitter
//   tx_busy   transmitter busy, high while shifting
//   busy      high whenever the scheduler is not IDLE
module laser_tx_sched #(
   parameter int NUM_REQ      = 4,
   parameter int PKT_LENGTH   = 32,
   parameter int GAP_CLKS     = 100,
   parameter int TIMEOUT_CLKS = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*PKT_LENGTH-1:0]  req_data,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             done,
   output logic                           err,
   output logic [PKT_LENGTH-1:0]          tx_data,
   output logic                           tx_start,
   input  logic                           tx_busy,
   output logic                           busy
);

   localparam int CTR_MAX  = (GAP_CLKS > TIMEOUT_CLKS) ? GAP_CLKS : TIMEOUT_CLKS;
   localparam int CTR_W    = $clog2(CTR_MAX + 1);
   localparam int PTR_W    = $clog2(NUM_REQ);
   localparam int GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;
   localparam int TO_LAST  = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_BUSY = 3'd2,
      WAIT_DONE = 3'd3,
      GAP       = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_nx;
   logic [CTR_W-1:0]       ctr;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       owner;

   logic                   win_vld;
   logic [PTR_W-1:0]       win_idx;
   logic [PTR_W-1:0]       cand;
   logic [PTR_W-1:0]       rr_nx;
   logic [PKT_LENGTH-1:0]  win_data;
   logic [NUM_REQ-1:0]     win_onehot;
   logic [NUM_REQ-1:0]     own_onehot;

   // Round-robin search starting at rr_ptr; first set request wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!win_vld && req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      win_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_idx == PTR_W'(k)) win_data = req_data[k*PKT_LENGTH +: PKT_LENGTH];
      end
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
      own_onehot          = '0;
      own_onehot[owner]   = 1'b1;
      rr_nx = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   end

   // Next-state logic. With GAP_CLKS = 0 the GAP state is skipped entirely.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (win_vld) state_nx = ISSUE;
         ISSUE:     state_nx = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_busy)                      state_nx = WAIT_DONE;
            else if (ctr == CTR_W'(TO_LAST))  state_nx = (GAP_CLKS == 0) ? IDLE : GAP;
         end
         WAIT_DONE: if (!tx_busy) state_nx = (GAP_CLKS == 0) ? IDLE : GAP;
         GAP:       if (ctr == CTR_W'(GAP_LAST)) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Registered outputs and datapath. Pulses default low every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant    <= '0;
         done     <= '0;
         err      <= 1'b0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         busy     <= 1'b0;
         ctr      <= '0;
         rr_ptr   <= '0;
         owner    <= '0;
      end else begin
         grant    <= '0;
         done     <= '0;
         err      <= 1'b0;
         tx_start <= 1'b0;
         busy     <= (state_nx != IDLE);
         case (state)
            IDLE: begin
               if (win_vld) begin
                  tx_data  <= win_data;
                  grant    <= win_onehot;
                  owner    <= win_idx;
                  rr_ptr   <= rr_nx;
                  tx_start <= 1'b1;
               end
            end
            ISSUE: ctr <= '0;
            WAIT_BUSY: begin
               if (!tx_busy) begin
                  if (ctr == CTR_W'(TO_LAST)) begin
                     err <= 1'b1;
                     // Restart the counter so the following GAP is full length.
                     ctr <= '0;
                  end else begin
                     ctr <= ctr + 1'b1;
                  end
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  done <= own_onehot;
                  ctr  <= '0;
               end
            end
            GAP: ctr <= ctr + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_laser_tx_sched.sv
// Testbench for laser_tx_sched: scoreboard of expected grant/done/err events,
// a transmitter model, and a second instance built with GAP_CLKS = 0.
module tb_laser_tx_sched;
   localparam int NR  = 4;
   localparam int PL  = 32;
   localparam int GAP = 4;
   localparam int TO  = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req = '0;
   logic [NR*PL-1:0]  req_data = '0;
   logic              tx_busy = 1'b0;
   logic [NR-1:0]     grant, done;
   logic              err, tx_start, busy;
   logic [PL-1:0]     tx_data;

   logic [NR-1:0]     req_g0 = '0;
   logic              tx_busy_g0 = 1'b0;
   logic [NR-1:0]     grant_g0, done_g0;
   logic              err_g0, tx_start_g0, busy_g0;
   logic [PL-1:0]     tx_data_g0;

   always #5 clk = ~clk;

   laser_tx_sched #(.NUM_REQ(NR), .PKT_LENGTH(PL), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TO)) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant), .done(done),
      .err(err), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .busy(busy));

   laser_tx_sched #(.NUM_REQ(NR), .PKT_LENGTH(PL), .GAP_CLKS(0), .TIMEOUT_CLKS(TO)) u_dut_g0 (
      .clk(clk), .rst(rst), .req(req_g0), .req_data(req_data), .grant(grant_g0), .done(done_g0),
      .err(err_g0), .tx_data(tx_data_g0), .tx_start(tx_start_g0), .tx_busy(tx_busy_g0), .busy(busy_g0));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      int            kind;   // 0 grant, 1 done, 2 err
      logic [NR-1:0] who;
      logic [PL-1:0] data;
   } ev_t;
   ev_t exp_q[$];
   ev_t mon_e;

   int ev_cnt = 0;
   int grant_cyc = 0, done_cyc = 0, err_cyc = 0, idle_cyc = 0, fall_cyc = 0;
   logic busy_prev = 1'b0;
   logic tx_en = 1'b1, tx_kill = 1'b0;
   int starts_g0[$];
   int fall_g0_cyc = 0, done_g0_cyc = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input logic [NR-1:0] who, input logic [PL-1:0] data);
      ev_t e;
      e.kind = kind; e.who = who; e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic wait_ev(input int target, input int budget, input string name);
      int n = 0;
      while (ev_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (ev_cnt < target) begin
         n_tests++; n_fail++;
         $display("FAIL %s: timeout, events=%0d required=%0d", name, ev_cnt, target);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial forever begin
      @(negedge clk);
      if (grant != '0 || done != '0 || err) begin
         ev_cnt++;
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_event: actual grant=%b done=%b err=%b required none", grant, done, err);
         end else begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
               0: begin
                  check("grant", 64'(grant), 64'(mon_e.who));
                  check("tx_data", 64'(tx_data), 64'(mon_e.data));
                  check("tx_start_with_grant", 64'(tx_start), 64'd1);
                  grant_cyc = cyc;
               end
               1: begin
                  check("done", 64'(done), 64'(mon_e.who));
                  done_cyc = cyc;
               end
               default: begin
                  check("err", 64'(err), 64'd1);
                  check("err_no_done", 64'(done), 64'd0);
                  err_cyc = cyc;
               end
            endcase
         end
      end
      if (busy_prev && !busy) idle_cyc = cyc;
      busy_prev = busy;
   end

   // Transmitter model: busy rises 2 cycles after tx_start, high for 40 cycles.
   initial forever begin
      @(negedge clk);
      if (tx_start && tx_en) begin
         @(posedge clk);
         @(posedge clk);
         #1;
         if (!tx_kill) begin
            tx_busy = 1'b1;
            for (int i = 0; i < 40 && !tx_kill; i++) @(posedge clk);
            #1;
            tx_busy  = 1'b0;
            fall_cyc = cyc;
         end
      end
   end

   // Transmitter model and observer for the GAP_CLKS = 0 instance.
   initial forever begin
      @(negedge clk);
      if (done_g0 != '0 && done_g0_cyc < 0) done_g0_cyc = cyc;
      if (tx_start_g0) begin
         starts_g0.push_back(cyc);
         check("g0_grant", 64'(grant_g0), 64'd1);
         @(posedge clk);
         @(posedge clk);
         #1 tx_busy_g0 = 1'b1;
         repeat (40) @(posedge clk);
         #1;
         tx_busy_g0  = 1'b0;
         fall_g0_cyc = cyc;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      int req_cyc;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_tx_start", 64'(tx_start), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;

      // 1: single request
      b = ev_cnt;
      req_data[31:0] = 32'hDEADBEEF;
      push_ev(0, 4'b0001, 32'hDEADBEEF);
      push_ev(1, 4'b0001, '0);
      req = 4'b0001;
      req_cyc = cyc;
      wait_ev(b + 1, 10, "t1_grant_wait");
      @(negedge clk) req = '0;
      check("t1_grant_latency", 64'(grant_cyc - req_cyc), 64'd1);
      wait_ev(b + 2, 80, "t1_done_wait");
      check("t1_done_after_fall", 64'(done_cyc - fall_cyc), 64'd1);
      repeat (8) @(posedge clk);
      check("t1_busy_low_after_done", 64'(idle_cyc - done_cyc), 64'd4);
      @(negedge clk);
      check("t1_tx_data_hold", 64'(tx_data), 64'hDEADBEEF);

      // Reset while idle so rr_ptr restarts at 0.
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;

      // 2: all four requesting, held
      for (int i = 0; i < NR; i++) req_data[i*PL +: PL] = 32'(i + 1);
      b = ev_cnt;
      for (int k = 0; k < 5; k++) begin
         push_ev(0, 4'(1 << (k % 4)), 32'((k % 4) + 1));
         push_ev(1, 4'(1 << (k % 4)), '0);
      end
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_ev(b + 2*k + 1, 100, "t2_grant_wait");
         if (k > 0) check("t2_start_after_fall", 64'(grant_cyc - fall_cyc), 64'd6);
         if (k == 4) @(negedge clk) req = '0;
         wait_ev(b + 2*k + 2, 100, "t2_done_wait");
      end
      repeat (8) @(posedge clk);

      // 3: transmitter dead -> timeout; rr_ptr ends at 3
      tx_en = 1'b0;
      b = ev_cnt;
      push_ev(0, 4'b0100, 32'd3);
      push_ev(2, '0, '0);
      @(negedge clk) req = 4'b0100;
      wait_ev(b + 1, 10, "t3_grant_wait");
      @(negedge clk) req = '0;
      wait_ev(b + 2, 30, "t3_err_wait");
      // 8 WAIT_BUSY cycles follow the tx_start cycle, then err is registered.
      check("t3_err_latency", 64'(err_cyc - grant_cyc), 64'd9);
      repeat (8) @(posedge clk);
      check("t3_idle_after_gap", 64'(idle_cyc - err_cyc), 64'd4);
      tx_en = 1'b1;
      b = ev_cnt;
      push_ev(0, 4'b1000, 32'd4);
      push_ev(1, 4'b1000, '0);
      @(negedge clk) req = 4'b1111;
      wait_ev(b + 1, 10, "t3_rr_grant_wait");
      @(negedge clk) req = '0;
      wait_ev(b + 2, 80, "t3_rr_done_wait");
      repeat (8) @(posedge clk);

      // 4: reset in WAIT_DONE (requester 1 wins, rr_ptr becomes 2 before reset)
      b = ev_cnt;
      push_ev(0, 4'b0010, 32'd2);
      @(negedge clk) req = 4'b0110;
      wait_ev(b + 1, 10, "t4_grant_wait");
      @(negedge clk) req = '0;
      for (int n = 0; n < 20 && !tx_busy; n++) @(posedge clk);
      check("t4_busy_rose", 64'(tx_busy), 64'd1);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; tx_kill = 1'b1;
      @(negedge clk);
      check("t4_rst_grant", 64'(grant), 64'd0);
      check("t4_rst_done", 64'(done), 64'd0);
      check("t4_rst_err", 64'(err), 64'd0);
      check("t4_rst_tx_data", 64'(tx_data), 64'd0);
      check("t4_rst_tx_start", 64'(tx_start), 64'd0);
      check("t4_rst_busy", 64'(busy), 64'd0);
      rst = 1'b0; tx_kill = 1'b0;
      // rr_ptr back at 0: requester 1 beats requester 2 again.
      b = ev_cnt;
      push_ev(0, 4'b0010, 32'd2);
      push_ev(1, 4'b0010, '0);
      push_ev(0, 4'b1000, 32'd4);
      push_ev(1, 4'b1000, '0);
      @(negedge clk) req = 4'b0110;
      wait_ev(b + 1, 10, "t4_regrant_wait");
      @(negedge clk) req = '0;

      // 5: requester 1 pulses while busy and drops; requester 3 then holds
      repeat (10) @(posedge clk);
      @(negedge clk) req = 4'b0010;
      @(negedge clk) req = '0;
      repeat (3) @(negedge clk);
      req = 4'b1000;
      wait_ev(b + 3, 120, "t5_grant_wait");
      @(negedge clk) req = '0;
      wait_ev(b + 4, 80, "t5_done_wait");
      repeat (60) @(posedge clk);
      check("t5_no_extra_events", 64'(ev_cnt - b), 64'd4);

      // 6: GAP_CLKS = 0 instance, req held
      @(negedge clk) req_g0 = 4'b0001;
      for (int n = 0; n < 200 && starts_g0.size() < 2; n++) @(posedge clk);
      @(negedge clk) req_g0 = '0;
      check("t6_two_starts", 64'(starts_g0.size() >= 2), 64'd1);
      if (starts_g0.size() >= 2)
         check("t6_restart_after_fall", 64'(starts_g0[1] - fall_g0_cyc), 64'd2);
      check("t6_done_after_fall", 64'(done_g0_cyc - fall_g0_cyc), 64'd1);
      repeat (60) @(posedge clk);

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
